// File: rtl/vga_sprite_pkg.sv
// Shared types and helpers for the VGA sprite pipeline.
//   sched_state_e : line scheduler FSM states
//   DEF_*         : default geometry used by the sprite blocks
//   row_hit()     : does a sprite whose top is at y cover a given line?
package vga_sprite_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StFetch,
      StCapture
   } sched_state_e;

   localparam int unsigned DEF_COORD_W  = 10;
   localparam int unsigned DEF_SPRITE_W = 8;
   localparam int unsigned DEF_SPRITE_H = 8;

   // Wrapped subtract: a sprite partly above the screen (y near 2^coord_w) still
   // produces a small row index on the first lines, which gives top-edge clipping.
   function automatic logic row_hit(input logic [31:0] line, input logic [31:0] y,
                                    input int unsigned coord_w, input int unsigned h);
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (coord_w >= 32) ? '1 : ((32'd1 << coord_w) - 32'd1);
      diff = (line - y) & mask;
      return diff < h;
   endfunction

endpackage

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite fetch scheduler.
// On line_start_i it walks every sprite slot, marks the slots covering the line
// and reads one bitmap row per covering slot from the shared single-port memory,
// strobing it into the pixel stage. Config writes share the memory port and are
// granted whenever the scheduler is not reading.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   line_start_i, line_i    start preparing line line_i
//   frame_start_i           clears the sticky overrun flag
//   spr_y_i                 packed top-y of every slot
//   cfg_req_i/addr/wdata    config write request; cfg_gnt_o when performed
//   mem_*                   sprite memory port (read data one cycle later)
//   slot_load_o, slot_row_o one-hot row load into the pixel stage
//   slot_valid_o            slots covering the prepared line
//   done_o                  pulse when the line is prepared
//   overrun_o               sticky: line_start_i arrived while busy
module sprite_line_sched
   import vga_sprite_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned SPRITE_W    = DEF_SPRITE_W,
   parameter int unsigned SPRITE_H    = DEF_SPRITE_H,
   parameter int unsigned COORD_W     = DEF_COORD_W,
   parameter int unsigned MEM_AW      = $clog2(NUM_SPRITES * SPRITE_H)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           line_start_i,
   input  logic [COORD_W-1:0]             line_i,
   input  logic                           frame_start_i,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_y_i,
   input  logic                           cfg_req_i,
   input  logic [MEM_AW-1:0]              cfg_addr_i,
   input  logic [SPRITE_W-1:0]            cfg_wdata_i,
   output logic                           cfg_gnt_o,
   output logic                           mem_en_o,
   output logic                           mem_we_o,
   output logic [MEM_AW-1:0]              mem_addr_o,
   output logic [SPRITE_W-1:0]            mem_wdata_o,
   input  logic [SPRITE_W-1:0]            mem_rdata_i,
   output logic [NUM_SPRITES-1:0]         slot_load_o,
   output logic [SPRITE_W-1:0]            slot_row_o,
   output logic [NUM_SPRITES-1:0]         slot_valid_o,
   output logic                           done_o,
   output logic                           overrun_o
);

   localparam int unsigned KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   sched_state_e           state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   logic [COORD_W-1:0]     line_q, line_d;
   logic [RW-1:0]          row_q, row_d;
   logic [NUM_SPRITES-1:0] valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   overrun_q, overrun_d;

   logic [COORD_W-1:0]     y_cur;
   logic                   hit;
   logic                   last;

   assign y_cur = spr_y_i[k_q*COORD_W +: COORD_W];
   assign hit   = row_hit(32'(line_q), 32'(y_cur), COORD_W, SPRITE_H);
   assign last  = (k_q == KW'(NUM_SPRITES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         k_q       <= '0;
         line_q    <= '0;
         row_q     <= '0;
         valid_q   <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         line_q    <= line_d;
         row_q     <= row_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      line_d  = line_q;
      row_d   = row_q;
      valid_d = valid_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (line_start_i) begin
               line_d  = line_i;
               valid_d = '0;
               k_d     = '0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (hit) begin
               valid_d[k_q] = 1'b1;
               // Row is latched so FETCH does not depend on spr_y_i staying put.
               row_d        = RW'(line_q - y_cur);
               state_d      = StFetch;
            end else if (last) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StFetch: begin
            state_d = StCapture;
         end
         StCapture: begin
            if (last) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = StCheck;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Set beats clear when both arrive together.
   always_comb begin
      overrun_d = overrun_q;
      if (line_start_i && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end else if (frame_start_i) begin
         overrun_d = 1'b0;
      end
   end

   // Memory port mux: scheduler read in FETCH, otherwise a config write if requested.
   always_comb begin
      cfg_gnt_o   = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      slot_load_o = '0;
      slot_row_o  = '0;
      if (!rst_i) begin
         if (state_q == StFetch) begin
            mem_en_o   = 1'b1;
            mem_addr_o = MEM_AW'(32'(k_q) * SPRITE_H + 32'(row_q));
         end else if (cfg_req_i) begin
            cfg_gnt_o   = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = cfg_addr_i;
            mem_wdata_o = cfg_wdata_i;
         end
         if (state_q == StCapture) begin
            slot_load_o[k_q] = 1'b1;
            slot_row_o       = mem_rdata_i;
         end
      end
   end

   assign slot_valid_o = valid_q;
   assign done_o       = done_q;
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched with a behavioural sprite memory.
module tb_sprite_line_sched;

   localparam int NCYC_MAX = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        line_start_i;
   logic [9:0]  line_i;
   logic        frame_start_i;
   logic [39:0] spr_y_i;
   logic        cfg_req_i;
   logic [4:0]  cfg_addr_i;
   logic [7:0]  cfg_wdata_i;
   logic        cfg_gnt_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [4:0]  mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic [7:0]  mem_rdata_i;
   logic [3:0]  slot_load_o;
   logic [7:0]  slot_row_o;
   logic [3:0]  slot_valid_o;
   logic        done_o;
   logic        overrun_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem [0:31];

   logic       en_t    [0:NCYC_MAX];
   logic       we_t    [0:NCYC_MAX];
   logic [4:0] addr_t  [0:NCYC_MAX];
   logic [3:0] load_t  [0:NCYC_MAX];
   logic [7:0] row_t   [0:NCYC_MAX];
   logic [3:0] valid_t [0:NCYC_MAX];
   logic       done_t  [0:NCYC_MAX];
   logic       gnt_t   [0:NCYC_MAX];
   logic       ov_t    [0:NCYC_MAX];

   sprite_line_sched dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .line_start_i (line_start_i),
      .line_i       (line_i),
      .frame_start_i(frame_start_i),
      .spr_y_i      (spr_y_i),
      .cfg_req_i    (cfg_req_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_gnt_o    (cfg_gnt_o),
      .mem_en_o     (mem_en_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .slot_load_o  (slot_load_o),
      .slot_row_o   (slot_row_o),
      .slot_valid_o (slot_valid_o),
      .done_o       (done_o),
      .overrun_o    (overrun_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 37 + 5) & 255);
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = init_val(i);
   end

   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata_i <= mem[mem_addr_o];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_y(input int a, input int b, input int c, input int d);
      spr_y_i = {10'(d), 10'(c), 10'(b), 10'(a)};
   endtask

   task automatic start_line(input int l);
      @(posedge clk);
      #1;
      line_start_i  = 1'b1;
      line_i        = 10'(l);
      frame_start_i = 1'b0;
   endtask

   // Cycle 0 is the one in which start_line raised line_start_i.
   task automatic run(input int lsc, input int fsc, input logic cfg, input int rstc,
                      input int ncyc);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         line_start_i  = (c == lsc);
         frame_start_i = (c == fsc);
         rst_i         = (c == rstc);
         cfg_req_i     = cfg;
         cfg_addr_i    = 5'(c - 1);
         cfg_wdata_i   = 8'(8'hC0 + c);
         @(negedge clk);
         en_t[c]    = mem_en_o;
         we_t[c]    = mem_we_o;
         addr_t[c]  = mem_addr_o;
         load_t[c]  = slot_load_o;
         row_t[c]   = slot_row_o;
         valid_t[c] = slot_valid_o;
         done_t[c]  = done_o;
         gnt_t[c]   = cfg_gnt_o;
         ov_t[c]    = overrun_o;
      end
      @(posedge clk);
      #1;
      line_start_i  = 1'b0;
      frame_start_i = 1'b0;
      rst_i         = 1'b0;
      cfg_req_i     = 1'b0;
   endtask

   function automatic int first_done(input int ncyc);
      for (int c = 1; c <= ncyc; c++) if (done_t[c]) return c;
      return -1;
   endfunction

   function automatic int count_loads(input int a, input int b);
      int n = 0;
      for (int c = a; c <= b; c++) if (load_t[c] != 4'b0) n++;
      return n;
   endfunction

   task automatic frame_pulse();
      @(posedge clk);
      #1;
      frame_start_i = 1'b1;
      @(posedge clk);
      #1;
      frame_start_i = 1'b0;
   endtask

   initial begin
      rst_i         = 1'b1;
      line_start_i  = 1'b0;
      line_i        = '0;
      frame_start_i = 1'b0;
      cfg_req_i     = 1'b1;
      cfg_addr_i    = 5'd0;
      cfg_wdata_i   = 8'hEE;
      set_y(10, 20, 30, 40);

      // Reset: no grant while in reset even with a request pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("gnt_in_reset", 32'(cfg_gnt_o), 0);
      check_eq("en_in_reset", 32'(mem_en_o), 0);
      @(posedge clk);
      #1;
      rst_i     = 1'b0;
      cfg_req_i = 1'b0;
      @(negedge clk);
      check_eq("rst_valid", 32'(slot_valid_o), 0);
      check_eq("rst_done", 32'(done_o), 0);
      check_eq("rst_overrun", 32'(overrun_o), 0);
      check_eq("rst_load", 32'(slot_load_o), 0);
      check_eq("rst_mem_en", 32'(mem_en_o), 0);
      check_eq("mem_untouched", 32'(mem[0]), 32'(init_val(0)));

      // Single hit: slot 0 row 3.
      start_line(13);
      run(-1, -1, 1'b0, -1, 10);
      check_eq("t1_fetch_en", 32'(en_t[2]), 1);
      check_eq("t1_fetch_we", 32'(we_t[2]), 0);
      check_eq("t1_fetch_addr", 32'(addr_t[2]), 3);
      check_eq("t1_load", 32'(load_t[3]), 32'b0001);
      check_eq("t1_row", 32'(row_t[3]), 32'(init_val(3)));
      check_eq("t1_done_cyc", 32'(first_done(10)), 7);
      check_eq("t1_done_width", 32'(done_t[8]), 0);
      check_eq("t1_valid", 32'(valid_t[7]), 32'b0001);
      check_eq("t1_loads", 32'(count_loads(1, 10)), 1);

      // All slots hit at row 7.
      set_y(0, 0, 0, 0);
      start_line(7);
      run(-1, -1, 1'b0, -1, 15);
      check_eq("t2_addr0", 32'(addr_t[2]), 7);
      check_eq("t2_addr1", 32'(addr_t[5]), 15);
      check_eq("t2_addr2", 32'(addr_t[8]), 23);
      check_eq("t2_addr3", 32'(addr_t[11]), 31);
      check_eq("t2_load3", 32'(load_t[12]), 32'b1000);
      check_eq("t2_row3", 32'(row_t[12]), 32'(init_val(31)));
      check_eq("t2_load1", 32'(load_t[6]), 32'b0010);
      check_eq("t2_valid", 32'(valid_t[13]), 32'b1111);
      check_eq("t2_done_cyc", 32'(first_done(15)), 13);

      // Top-edge clip: slot 2 at y=1020 covers line 2 at row 6.
      set_y(500, 600, 1020, 700);
      start_line(2);
      run(-1, -1, 1'b0, -1, 10);
      check_eq("t3_addr", 32'(addr_t[4]), 22);
      check_eq("t3_en", 32'(en_t[4]), 1);
      check_eq("t3_load", 32'(load_t[5]), 32'b0100);
      check_eq("t3_valid", 32'(valid_t[7]), 32'b0100);
      check_eq("t3_done_cyc", 32'(first_done(10)), 7);
      start_line(8);
      run(-1, -1, 1'b0, -1, 8);
      check_eq("t3b_valid", 32'(valid_t[5]), 0);
      check_eq("t3b_done_cyc", 32'(first_done(8)), 5);
      check_eq("t3b_loads", 32'(count_loads(1, 8)), 0);

      // Overrun: second line_start at cycle 4 is dropped.
      set_y(10, 20, 30, 40);
      start_line(13);
      run(4, -1, 1'b0, -1, 10);
      check_eq("ov_before", 32'(ov_t[4]), 0);
      check_eq("ov_set", 32'(ov_t[5]), 1);
      check_eq("ov_done_cyc", 32'(first_done(10)), 7);
      check_eq("ov_ignored", 32'(count_loads(8, 10)), 0);
      frame_pulse();
      @(negedge clk);
      check_eq("ov_cleared", 32'(overrun_o), 0);

      // Overrun and frame start together: set wins.
      start_line(13);
      run(2, 2, 1'b0, -1, 10);
      check_eq("ov_set_wins", 32'(ov_t[3]), 1);
      frame_pulse();
      @(negedge clk);
      check_eq("ov_cleared2", 32'(overrun_o), 0);

      // line_start coinciding with done is accepted.
      start_line(13);
      run(7, -1, 1'b0, -1, 16);
      check_eq("b2b_done1", 32'(done_t[7]), 1);
      check_eq("b2b_fetch_addr", 32'(addr_t[9]), 3);
      check_eq("b2b_fetch_en", 32'(en_t[9]), 1);
      check_eq("b2b_done2", 32'(done_t[14]), 1);
      check_eq("b2b_no_ov", 32'(ov_t[9]), 0);

      // Reset during FETCH aborts the line.
      set_y(0, 0, 0, 0);
      start_line(7);
      run(-1, -1, 1'b0, 2, 15);
      check_eq("rst_mid_en", 32'(en_t[3]), 0);
      check_eq("rst_mid_valid", 32'(valid_t[3]), 0);
      check_eq("rst_mid_loads", 32'(count_loads(2, 15)), 0);
      check_eq("rst_mid_done", 32'(first_done(15)), 32'(-1));
      set_y(10, 20, 30, 40);
      start_line(13);
      run(-1, -1, 1'b0, -1, 10);
      check_eq("post_rst_load", 32'(load_t[3]), 32'b0001);
      check_eq("post_rst_done", 32'(first_done(10)), 7);

      // Config writes held through a full-hit line; write addr c-1, data C0+c.
      set_y(0, 0, 0, 0);
      start_line(7);
      run(-1, -1, 1'b1, -1, 13);
      begin
         int lows;
         lows = 0;
         for (int c = 1; c <= 13; c++) if (!gnt_t[c]) lows++;
         check_eq("cfg_gnt_lows", 32'(lows), 4);
      end
      check_eq("cfg_gnt_fetch0", 32'(gnt_t[2]), 0);
      check_eq("cfg_gnt_fetch3", 32'(gnt_t[11]), 0);
      check_eq("cfg_gnt_capture", 32'(gnt_t[3]), 1);
      check_eq("cfg_we_capture", 32'(we_t[3]), 1);
      check_eq("cfg_row0", 32'(row_t[3]), 32'(init_val(7)));
      check_eq("cfg_done_cyc", 32'(first_done(13)), 13);
      check_eq("cfg_mem0", 32'(mem[0]), 32'hC1);
      check_eq("cfg_mem1", 32'(mem[1]), 32'(init_val(1)));
      check_eq("cfg_mem2", 32'(mem[2]), 32'hC3);
      check_eq("cfg_mem7", 32'(mem[7]), 32'(init_val(7)));
      check_eq("cfg_mem12", 32'(mem[12]), 32'hCD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_line_sched.md
# sprite_line_sched

Per-scanline sprite fetch scheduler for the VGA sprite pipeline. During each horizontal blanking interval it scans all sprite slots and determines which slots cover the upcoming line. For each covering slot it reads one bitmap row from the shared sprite memory and hands that row to the pixel stage. It also arbitrates the same single-port memory between its own fetches and SPI-side configuration writes.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprite slots; valid range 1..16.
- SPRITE_W, 8, bitmap row width in bits (1 bpp mask); also the memory data width.
- SPRITE_H, 8, sprite height in rows; must be a power of two.
- COORD_W, 10, width of line and y coordinates.
- MEM_AW, $clog2(NUM_SPRITES*SPRITE_H), sprite memory address width (derived).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- line_start_i  in  1  one-cycle pulse at hblank start; requests preparation of the next line.
- line_i  in  COORD_W  y of the line to prepare; sampled with line_start_i.
- frame_start_i  in  1  one-cycle pulse at frame start.
- spr_y_i  in  NUM_SPRITES*COORD_W  top y of each slot; slot k is at [k*COORD_W +: COORD_W].
- cfg_req_i  in  1  SPI-side memory write request.
- cfg_addr_i  in  MEM_AW  write address.
- cfg_wdata_i  in  SPRITE_W  write data.
- cfg_gnt_o  out  1  write granted and performed this cycle.
- mem_en_o  out  1  memory enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  MEM_AW  memory address.
- mem_wdata_o  out  SPRITE_W  memory write data.
- mem_rdata_i  in  SPRITE_W  memory read data; valid one cycle after the read.
- slot_load_o  out  NUM_SPRITES  one-hot strobe; loads slot_row_o into the selected slot's shifter.
- slot_row_o  out  SPRITE_W  fetched row.
- slot_valid_o  out  NUM_SPRITES  slot k covers the prepared line.
- done_o  out  1  one-cycle pulse when the line is fully prepared.
- overrun_o  out  1  sticky flag: a line_start_i pulse arrived while the scheduler was busy.

## Operation
- FSM states: IDLE, CHECK, FETCH, CAPTURE.
- IDLE
  - line_start_i latches line_i, clears slot_valid_o, sets k=0 and moves to CHECK.
- CHECK
  - row = line − spr_y[k], computed modulo 2^COORD_W. This wrap gives top-edge clipping.
  - Hit when row < SPRITE_H (unsigned compare); a hit sets slot_valid_o[k] and moves to FETCH.
  - On a miss: if k = NUM_SPRITES−1 go to IDLE, else k++ and stay in CHECK.
- FETCH
  - Drives mem_en_o=1, mem_we_o=0, mem_addr_o = k*SPRITE_H + row[log2(SPRITE_H)−1:0]. Next state is CAPTURE.
- CAPTURE
  - slot_row_o = mem_rdata_i and slot_load_o = 1<<k, both combinational.
  - Then go to IDLE if k is the last slot, otherwise k++ and go to CHECK.
- spr_y_i is sampled live in CHECK. Only line_i is latched.
- done_o is registered and is high for the first IDLE cycle after the last slot has been processed.
- Arbitration:
  - cfg_gnt_o = cfg_req_i && state != FETCH, combinational. The scheduler has absolute priority.
  - When granted, the memory port carries the write (en=1, we=1, cfg_addr_i, cfg_wdata_i) in the same cycle.
  - A write during CAPTURE is legal because the read data was already returned for the FETCH cycle.
- Overrun:
  - A line_start_i pulse outside IDLE is ignored, and overrun_o is set.
  - frame_start_i clears overrun_o. If a line_start_i overrun and frame_start_i arrive in the same cycle, the set wins.
- frame_start_i does not otherwise affect the FSM.

## Timing
- Reset values: state IDLE; slot_load_o, slot_valid_o, done_o, overrun_o, mem_en_o, mem_we_o all 0; mem_addr_o, mem_wdata_o, slot_row_o 0.
- During reset, cfg_gnt_o = 0.
- Reset mid-line aborts immediately: no further slot_load_o and no done_o.
- Cycle numbering: line_start_i accepted at cycle 0, first CHECK at cycle 1.
- Each miss costs 1 cycle; each hit costs 3 cycles.
- done_o is asserted at cycle (misses + 3*hits + 1).
- Worst case is 3*NUM_SPRITES+1 cycles; this must fit in the hblank period.
- A line_start_i in the same cycle as done_o is accepted, because the state is IDLE.

## Structure
- Package vga_sprite_pkg holds:
  - the state enum;
  - default COORD_W, SPRITE_W and SPRITE_H;
  - the row-hit function: wrapped subtract plus compare.
- No sub-module is needed. A single FSM plus a combinational memory mux fits in about 200 lines.

## Test plan
- N=4, H=8, y={10,20,30,40}, line=13 → only slot 0 hits at row 3; mem_addr_o=3 in FETCH at cycle 2; slot_load_o=0001 at cycle 3; done_o at cycle 7.
- All y=0, line=7 → four fetches at addresses 7, 15, 23, 31; slot_valid_o=1111; done_o at cycle 13.
- y[2]=1020 (COORD_W=10), line=2 → row=6 via wrap, so slot 2 hits at address 22. line=8 → no hit.
- cfg_req_i held high through a full-hit line → cfg_gnt_o low exactly during the 4 FETCH cycles; each granted write lands in memory with the correct address and data.
- Second line_start_i at cycle 4 → ignored and overrun_o=1. frame_start_i then clears overrun_o. A simultaneous line_start_i overrun and frame_start_i leaves overrun_o=1.
- rst_i asserted during FETCH → all outputs are zero the next cycle and no done_o follows. The next line_start_i operates normally.
